// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotation: angle (deg, Q10.22) -> cos/sin (1.0 = 2^25), ITER cycles start-to-done; start ignored while busy.
// Define CORDIC_ROT_QUADRANT_EN for full-circle input; default build saturates the angle to +/-90 deg.
module cordic_rotator #(
  parameter int                 ITER  = 16,
  parameter logic signed [31:0] KINIT = 32'sd20376027
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] angle_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out
);

  localparam logic signed [31:0] DEG90 = 32'sd377487360;
`ifdef CORDIC_ROT_QUADRANT_EN
  localparam logic signed [31:0] DEG180 = 32'sd754974720;
`endif

  typedef enum logic {IDLE, ROTATE} state_t;

  state_t             state;
  logic signed [31:0] x, y, z;
  logic [4:0]         cnt;
  logic signed [31:0] ang_sat, x_ld, y_ld, z_ld;
  logic signed [31:0] x_sh, y_sh, atan_i, x_nx, y_nx, z_nx;

  // atan(2^-i) in degrees, Q10.22
  function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  atan_lut = 32'sd188743680;
      5'd1:  atan_lut = 32'sd111421900;
      5'd2:  atan_lut = 32'sd58872272;
      5'd3:  atan_lut = 32'sd29884485;
      5'd4:  atan_lut = 32'sd15000234;
      5'd5:  atan_lut = 32'sd7507429;
      5'd6:  atan_lut = 32'sd3754631;
      5'd7:  atan_lut = 32'sd1877430;
      5'd8:  atan_lut = 32'sd938729;
      5'd9:  atan_lut = 32'sd469366;
      5'd10: atan_lut = 32'sd234683;
      5'd11: atan_lut = 32'sd117342;
      5'd12: atan_lut = 32'sd58671;
      5'd13: atan_lut = 32'sd29335;
      5'd14: atan_lut = 32'sd14668;
      5'd15: atan_lut = 32'sd7334;
      5'd16: atan_lut = 32'sd3667;
      5'd17: atan_lut = 32'sd1833;
      5'd18: atan_lut = 32'sd917;
      5'd19: atan_lut = 32'sd458;
      5'd20: atan_lut = 32'sd229;
      5'd21: atan_lut = 32'sd115;
      5'd22: atan_lut = 32'sd57;
      5'd23: atan_lut = 32'sd29;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  always_comb begin
    x_ld = KINIT;
    y_ld = '0;
`ifdef CORDIC_ROT_QUADRANT_EN
    if (angle_in > DEG180)       ang_sat = DEG180;
    else if (angle_in < -DEG180) ang_sat = -DEG180;
    else                         ang_sat = angle_in;
    z_ld = ang_sat;
    // Outer quadrants start from a vector already turned by +/-90 deg
    if (ang_sat > DEG90) begin
      x_ld = '0;
      y_ld = KINIT;
      z_ld = ang_sat - DEG90;
    end else if (ang_sat < -DEG90) begin
      x_ld = '0;
      y_ld = -KINIT;
      z_ld = ang_sat + DEG90;
    end
`else
    if (angle_in > DEG90)       ang_sat = DEG90;
    else if (angle_in < -DEG90) ang_sat = -DEG90;
    else                        ang_sat = angle_in;
    z_ld = ang_sat;
`endif
  end

  assign x_sh   = x >>> cnt;
  assign y_sh   = y >>> cnt;
  assign atan_i = atan_lut(cnt);

  always_comb begin
    if (!z[31]) begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan_i;
    end else begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x     <= x_ld;
          y     <= y_ld;
          z     <= z_ld;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ROTATE;
        end
      end else begin
        x   <= x_nx;
        y   <= y_nx;
        z   <= z_nx;
        cnt <= cnt + 5'd1;
        if (cnt == 5'(ITER - 1)) begin
          cos_out <= x_nx;
          sin_out <= y_nx;
          done    <= 1'b1;
          busy    <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Randomised bench for cordic_rotator: a trig reference model feeds a scoreboard queue,
// and a negedge monitor checks busy/done timing and the cos/sin results.
module tb_cordic_rotator;

  localparam int ITER = 16;
  localparam int TOL  = 2048;

  localparam int A30  = 125829120;
  localparam int A60  = 251658240;
  localparam int AM90 = -377487360;
  localparam int A150 = 629145600;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] angle_in;
  logic               busy;
  logic               done;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  cordic_rotator #(.ITER(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .angle_in (angle_in),
    .busy     (busy),
    .done     (done),
    .cos_out  (cos_out),
    .sin_out  (sin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int c;
    int s;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  int   last_acc = -1000;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req, input longint tol);
    total++;
    if (act > req + tol || act < req - tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  // Ideal trig of the saturated angle, scaled to 2^25
  function automatic void ref_cs(input int a, output int c, output int s);
    real lim, d, r;
`ifdef CORDIC_ROT_QUADRANT_EN
    lim = 180.0;
`else
    lim = 90.0;
`endif
    d = real'(a) / 4194304.0;
    if (d > lim)  d = lim;
    if (d < -lim) d = -lim;
    r = d * 3.14159265358979323846 / 180.0;
    c = int'($cos(r) * 33554432.0);
    s = int'($sin(r) * 33554432.0);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives one start pulse; the model accepts it only if the engine is free at the coming edge.
  task automatic issue(input int a);
    int c, s;
    start    = 1'b1;
    angle_in = a;
    if (cyc >= last_acc + ITER) begin
      ref_cs(a, c, s);
      last_acc = cyc + 1;
      sb.push_back('{cyc + 1 + ITER, c, s});
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 4 * ITER) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0, 0);
      sb.delete();
      last_acc = -1000;
    end
  endtask

  task automatic wait_done_cycle();
    while (cyc < last_acc + ITER) step();
  endtask

  always @(negedge clk) begin : monitor
    bit   exp_busy, exp_done;
    exp_t e;
    if (mon_en) begin
      exp_busy = (cyc >= last_acc) && (cyc < last_acc + ITER);
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      check("busy", busy, exp_busy, 0);
      check("done", done, exp_done, 0);
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        check("cos", cos_out, e.c, TOL);
        check("sin", sin_out, e.s, TOL);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    repeat (3) step();
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_cos", cos_out, 0, 0);
    check("reset_sin", sin_out, 0, 0);
    step();

    // Directed angles: 30, 0, -90, 150 degrees
    issue(A30);  wait_idle();
    issue(0);    wait_idle();
    issue(AM90); wait_idle();
    issue(A150); wait_idle();

    // Start while busy is ignored; start in the done cycle is taken
    issue(A30);
    repeat (4) step();
    issue(A60);
    wait_done_cycle();
    issue(A60);
    wait_idle();

    // Reset in the middle of an operation
    issue(A30);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    last_acc = -1000;
    sb.delete();
    @(negedge clk);
    check("midrst_busy", busy, 0, 0);
    check("midrst_cos", cos_out, 0, 0);
    check("midrst_sin", sin_out, 0, 0);
    step();
    issue(0);
    wait_idle();

    // Random angles over +/-200 deg with random spacing
    for (int n = 0; n < 40; n++) begin
      int a;
      a = int'($urandom_range(0, 1677721600)) - 838860800;
      if ($urandom_range(0, 3) == 0) wait_done_cycle();
      else repeat ($urandom_range(0, 20)) step();
      issue(a);
    end
    wait_idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
